// File: rtl/tdm_demux.sv
// Time-division demultiplexer: steers framed beats of one valid/ready stream
// to per-slot output channels, each behind a one-entry skid register.

module tdm_demux_ch #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // A load wins over a drain: the held beat leaves in the same cycle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = ld_data;
    end else if (ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
endmodule

module tdm_demux #(
  parameter  int WIDTH = 8,
  parameter  int N_CH  = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_sof,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [N_CH*WIDTH-1:0] out_data,
  output logic [N_CH-1:0]       out_valid,
  input  logic [N_CH-1:0]       out_ready,
  output logic [SEL_W-1:0]      slot,
  output logic [15:0]           frame_cnt,
  output logic                  sync_err
);
  typedef enum logic {HUNT, ROUTE} state_e;
  typedef struct packed {
    logic             sof;
    logic [WIDTH-1:0] data;
  } beat_t;

  state_e                     state_q, state_d;
  logic [SEL_W-1:0]           slot_q, slot_d;
  logic [15:0]                frame_cnt_q, frame_cnt_d;
  logic                       sync_err_q, sync_err_d;
  logic [N_CH-1:0]            load;
  logic [N_CH-1:0][WIDTH-1:0] ch_data;
  logic [SEL_W-1:0]           tgt;
  logic                       tgt_free, acc;
  beat_t                      in_beat;

  assign in_beat = '{sof: in_sof, data: in_data};

  // Only the targeted channel throttles the input; HUNT drops non-SOF beats freely.
  always_comb begin
    tgt      = in_beat.sof ? '0 : slot_q;
    tgt_free = ~out_valid[tgt] | out_ready[tgt];
    if (state_q == HUNT) in_ready = rst_n & (~in_beat.sof | tgt_free);
    else                 in_ready = rst_n & tgt_free;
  end

  assign acc = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    frame_cnt_d = frame_cnt_q;
    sync_err_d  = 1'b0;
    load        = '0;
    if (acc) begin
      case (state_q)
        HUNT: begin
          if (in_beat.sof) begin
            load[0] = 1'b1;
            slot_d  = SEL_W'(1);
            state_d = ROUTE;
          end
        end
        default: begin
          if (in_beat.sof) begin
            // Early SOF abandons the partial frame without counting it.
            load[0]    = 1'b1;
            slot_d     = SEL_W'(1);
            sync_err_d = (slot_q != '0);
          end else if (slot_q == '0) begin
            sync_err_d = 1'b1;
            state_d    = HUNT;
          end else begin
            load[slot_q] = 1'b1;
            slot_d       = slot_q + 1'b1;
            if (slot_q == SEL_W'(N_CH-1)) frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      slot_q      <= '0;
      frame_cnt_q <= '0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      frame_cnt_q <= frame_cnt_d;
      sync_err_q  <= sync_err_d;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    tdm_demux_ch #(.WIDTH(WIDTH)) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load[k]),
      .ld_data(in_beat.data),
      .ready  (out_ready[k]),
      .valid  (out_valid[k]),
      .data   (ch_data[k])
    );
  end

  assign out_data  = ch_data;
  assign slot      = slot_q;
  assign frame_cnt = frame_cnt_q;
  assign sync_err  = sync_err_q;
endmodule
